// File: rtl/seg_serial_tx.sv
// seg_serial_tx: parallel-to-serial transmitter for the cascaded shift-register
// seven-segment display chain. It captures a panel-ordered pattern and shifts it
// out MSB-first on a divided serial clock, then pulses the latch enable.
module seg_serial_tx #(
    parameter int unsigned DATA_BITS = 64,
    parameter int unsigned CLK_DIV   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] p_data,
    output logic                 busy,
    output logic                 done,
    output logic                 s_clk,
    output logic                 s_dout,
    output logic                 s_clr_n,
    output logic                 s_en
);

    localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StLatch = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 s_clk_q, s_clk_d;
    logic                 s_clr_n_q, s_clr_n_d;
    logic                 s_en_q, s_en_d;

    logic                 div_end;
    logic                 last_bit;
    logic [DATA_BITS-1:0] shreg_shift;

    // Half-period boundary, final-bit detect and the zero-filled shift value.
    always_comb begin
        div_end     = (div_q == DIV_LAST);
        last_bit    = (bit_cnt_q == BIT_LAST);
        shreg_shift = shreg_q << 1;
    end

    // Next-state logic for the IDLE / SHIFT / LATCH sequencer and its outputs.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_d     = div_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        s_clk_d   = s_clk_q;
        s_clr_n_d = 1'b1;
        s_en_d    = s_en_q;

        case (state_q)
            StIdle: begin
                s_clk_d = 1'b0;
                s_en_d  = 1'b0;
                if (start) begin
                    shreg_d   = p_data;
                    bit_cnt_d = '0;
                    div_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = StShift;
                end
            end

            StShift: begin
                if (div_end) begin
                    div_d = '0;
                    if (!s_clk_q) begin
                        // End of low half: rising edge, data already stable.
                        s_clk_d = 1'b1;
                    end else begin
                        // End of high half: fall and present the next bit together.
                        s_clk_d   = 1'b0;
                        shreg_d   = shreg_shift;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (last_bit) begin
                            s_en_d  = 1'b1;
                            state_d = StLatch;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            StLatch: begin
                s_clk_d = 1'b0;
                if (div_end) begin
                    div_d   = '0;
                    s_en_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                s_clk_d = 1'b0;
                s_en_d  = 1'b0;
            end
        endcase
    end

    // Sequencer state, datapath and counters; synchronous reset clears all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_q     <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_q     <= div_d;
        end
    end

    // Registered status and pin outputs; clear is held low while in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            s_clk_q   <= 1'b0;
            s_clr_n_q <= 1'b0;
            s_en_q    <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            s_clk_q   <= s_clk_d;
            s_clr_n_q <= s_clr_n_d;
            s_en_q    <= s_en_d;
        end
    end

    // Serial data is the shift-register MSB, so it only moves on the falling half.
    always_comb begin
        busy    = busy_q;
        done    = done_q;
        s_clk   = s_clk_q;
        s_dout  = shreg_q[DATA_BITS-1];
        s_clr_n = s_clr_n_q;
        s_en    = s_en_q;
    end

endmodule
